// File: rtl/slow_dev_responder.sv
// Device-side responder for the CPU clock-stall protocol.
// A CPU access that hits the slow window raises WAIT_SIGNAL, which freezes the
// gated CPU clock. The access is then forwarded to the slow device as a
// req/ack transaction, and a single HANDSHAKE pulse releases the CPU clock.
// If the device does not answer in time, the access completes with ERR_VALUE
// and a sticky TIMEOUT_ERR flag is set.
module slow_dev_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] SLOW_BASE  = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] SLOW_MASK  = 32'hFFFF_F000,
  parameter int                    TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_VALUE  = 32'hDEAD_BEEF
) (
  input  logic                  MASTER_CLK,
  input  logic                  RESET_N,
  input  logic                  MEM_REQ,
  input  logic                  MEM_WE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  WAIT_SIGNAL,
  output logic                  HANDSHAKE,
  output logic                  DEV_REQ,
  output logic                  DEV_WE,
  output logic [ADDR_WIDTH-1:0] DEV_ADDR,
  output logic [DATA_WIDTH-1:0] DEV_WDATA,
  input  logic                  DEV_ACK,
  input  logic [DATA_WIDTH-1:0] DEV_RDATA,
  output logic                  TIMEOUT_ERR,
  input  logic                  ERR_CLEAR
);

  // Counter is wide enough to hold TIMEOUT, so it never wraps inside one access.
  localparam int             CNT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    RELEASE  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] count;
  logic                 hit;

  // An access is for us only when the masked address matches the window base.
  assign hit = MEM_REQ && ((ADDR & SLOW_MASK) == (SLOW_BASE & SLOW_MASK));

  // Control FSM; every output is a register updated here.
  always_ff @(posedge MASTER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      count       <= '0;
      WAIT_SIGNAL <= 1'b0;
      HANDSHAKE   <= 1'b0;
      DEV_REQ     <= 1'b0;
      DEV_WE      <= 1'b0;
      DEV_ADDR    <= '0;
      DEV_WDATA   <= '0;
      RDATA       <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      // Clear first so that a timeout on the same edge overrides it below.
      if (ERR_CLEAR) begin
        TIMEOUT_ERR <= 1'b0;
      end

      case (state)
        IDLE: begin
          // DEV_ACK is deliberately ignored here: no request is outstanding.
          if (hit) begin
            DEV_ADDR    <= ADDR;
            DEV_WDATA   <= WDATA;
            DEV_WE      <= MEM_WE;
            WAIT_SIGNAL <= 1'b1;
            DEV_REQ     <= 1'b1;
            count       <= '0;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          count <= count + 1'b1;
          // An ack always wins over a timeout falling on the same cycle.
          if (DEV_ACK) begin
            if (!DEV_WE) begin
              RDATA <= DEV_RDATA;
            end
            DEV_REQ   <= 1'b0;
            HANDSHAKE <= 1'b1;
            state     <= RELEASE;
          end else if (count == CNT_LAST) begin
            if (!DEV_WE) begin
              RDATA <= ERR_VALUE;
            end
            TIMEOUT_ERR <= 1'b1;
            DEV_REQ     <= 1'b0;
            HANDSHAKE   <= 1'b1;
            state       <= RELEASE;
          end
        end

        RELEASE: begin
          // HANDSHAKE was high with WAIT_SIGNAL for exactly this one cycle.
          WAIT_SIGNAL <= 1'b0;
          HANDSHAKE   <= 1'b0;
          state       <= COOLDOWN;
        end

        COOLDOWN: begin
          // The CPU's request from the finished access is still on the bus.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slow_dev_responder.sv
// Directed bench for slow_dev_responder with a timestamp-based reference model.
module tb_slow_dev_responder;

  localparam int          TMO       = 8;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam logic [31:0] MASK      = 32'hFFFF_F000;
  localparam logic [31:0] ERR_VALUE = 32'hDEAD_BEEF;

  logic        MASTER_CLK = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        MEM_REQ    = 1'b0;
  logic        MEM_WE     = 1'b0;
  logic [31:0] ADDR       = '0;
  logic [31:0] WDATA      = '0;
  logic [31:0] RDATA;
  logic        WAIT_SIGNAL;
  logic        HANDSHAKE;
  logic        DEV_REQ;
  logic        DEV_WE;
  logic [31:0] DEV_ADDR;
  logic [31:0] DEV_WDATA;
  logic        DEV_ACK    = 1'b0;
  logic [31:0] DEV_RDATA  = '0;
  logic        TIMEOUT_ERR;
  logic        ERR_CLEAR  = 1'b0;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  slow_dev_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .SLOW_BASE (BASE),
    .SLOW_MASK (MASK),
    .TIMEOUT   (TMO),
    .ERR_VALUE (ERR_VALUE)
  ) dut (
    .MASTER_CLK (MASTER_CLK),
    .RESET_N    (RESET_N),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .RDATA      (RDATA),
    .WAIT_SIGNAL(WAIT_SIGNAL),
    .HANDSHAKE  (HANDSHAKE),
    .DEV_REQ    (DEV_REQ),
    .DEV_WE     (DEV_WE),
    .DEV_ADDR   (DEV_ADDR),
    .DEV_WDATA  (DEV_WDATA),
    .DEV_ACK    (DEV_ACK),
    .DEV_RDATA  (DEV_RDATA),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .ERR_CLEAR  (ERR_CLEAR)
  );

  always #5 MASTER_CLK = ~MASTER_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (edge timestamps) ----------------
  // An access occupies edges start_e..end_e; end_e is the edge where the ack
  // or the timeout is sampled. HANDSHAKE is the cycle right after end_e, one
  // cooldown cycle follows, so the next hit can be sampled at end_e+3.
  int          cyc     = 0;
  int          start_e = -100;
  int          end_e   = -100;
  bit          in_txn  = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  bit          m_we    = 1'b0;
  bit          m_err   = 1'b0;

  initial begin
    bit tmo;
    forever begin
      @(posedge MASTER_CLK or negedge RESET_N);
      if (!RESET_N) begin
        in_txn  = 1'b0;
        end_e   = -100;
        m_rdata = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_we    = 1'b0;
        m_err   = 1'b0;
      end else begin
        cyc++;
        tmo = 1'b0;
        if (in_txn) begin
          if (DEV_ACK) begin
            in_txn = 1'b0;
            end_e  = cyc;
            if (!m_we) m_rdata = DEV_RDATA;
          end else if (cyc - start_e == TMO) begin
            in_txn = 1'b0;
            end_e  = cyc;
            tmo    = 1'b1;
            if (!m_we) m_rdata = ERR_VALUE;
          end
          if (!in_txn)
            $display("txn addr=%h we=%0d wdata=%h rdata=%h cycles=%0d timeout=%0d",
                     m_addr, m_we, m_wdata, m_rdata, end_e - start_e, tmo);
        end else if (cyc >= end_e + 3 && MEM_REQ && ((ADDR & MASK) == (BASE & MASK))) begin
          in_txn  = 1'b1;
          start_e = cyc;
          m_addr  = ADDR;
          m_wdata = WDATA;
          m_we    = MEM_WE;
        end
        if (tmo) m_err = 1'b1;
        else if (ERR_CLEAR) m_err = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    bit exp_wait, exp_hs, exp_req;
    forever begin
      @(negedge MASTER_CLK);
      if (chk_en) begin
        exp_req  = in_txn;
        exp_hs   = !in_txn && (cyc == end_e);
        exp_wait = in_txn || exp_hs;
        chk("wait_signal", 32'(WAIT_SIGNAL), 32'(exp_wait));
        chk("handshake",   32'(HANDSHAKE),   32'(exp_hs));
        chk("dev_req",     32'(DEV_REQ),     32'(exp_req));
        chk("dev_we",      32'(DEV_WE),      32'(m_we));
        chk("dev_addr",    DEV_ADDR,         m_addr);
        chk("dev_wdata",   DEV_WDATA,        m_wdata);
        chk("rdata",       RDATA,            m_rdata);
        chk("timeout_err", 32'(TIMEOUT_ERR), 32'(m_err));
        if (HANDSHAKE && !WAIT_SIGNAL) chk("hs_without_wait", 32'(1), 32'(0));
      end
    end
  end

  // ---------------- slow device ----------------
  // Acks ack_lat cycles after DEV_REQ rises (ack_lat=0: never acks).
  int          ack_lat  = 0;
  logic [31:0] dev_data = '0;

  initial begin
    int req_cycles;
    req_cycles = 0;
    forever begin
      @(negedge MASTER_CLK);
      DEV_ACK = 1'b0;
      if (DEV_REQ) begin
        req_cycles++;
        if (ack_lat != 0 && req_cycles == ack_lat) begin
          DEV_ACK   = 1'b1;
          DEV_RDATA = dev_data;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // Advance past one active edge and settle on the following falling edge.
  task automatic tick();
    @(posedge MASTER_CLK);
    @(negedge MASTER_CLK);
  endtask

  task automatic cpu_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    MEM_REQ = 1'b1;
    MEM_WE  = we;
    ADDR    = a;
    WDATA   = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge MASTER_CLK);
    chk_en = 1'b1;
    chk("reset_wait",  32'(WAIT_SIGNAL), 32'(0));
    chk("reset_rdata", RDATA,            32'h0);
    chk("reset_err",   32'(TIMEOUT_ERR), 32'(0));
    chk("reset_addr",  DEV_ADDR,         32'h0);
    RESET_N = 1'b1;
    tick();

    // Read with ack three cycles after DEV_REQ.
    ack_lat = 3; dev_data = 32'h1234_5678;
    cpu_req(1'b0, 32'h0000_1004, 32'h0);
    tick();
    chk("rd_wait_up",   32'(WAIT_SIGNAL), 32'(1));
    chk("rd_dev_addr",  DEV_ADDR,         32'h0000_1004);
    MEM_REQ = 1'b0;
    tick(); tick();
    chk("rd_hs_early",  32'(HANDSHAKE),   32'(0));
    tick();
    chk("rd_hs_pulse",  32'(HANDSHAKE),   32'(1));
    chk("rd_rdata",     RDATA,            32'h1234_5678);
    tick();
    chk("rd_hs_done",   32'(HANDSHAKE),   32'(0));
    chk("rd_wait_down", 32'(WAIT_SIGNAL), 32'(0));
    tick(); tick();

    // Write with immediate ack.
    ack_lat = 1;
    cpu_req(1'b1, 32'h0000_1010, 32'hA5A5_A5A5);
    tick();
    chk("wr_dev_we",    32'(DEV_WE),      32'(1));
    chk("wr_dev_wdata", DEV_WDATA,        32'hA5A5_A5A5);
    MEM_REQ = 1'b0;
    tick();
    chk("wr_hs_pulse",  32'(HANDSHAKE),   32'(1));
    chk("wr_rdata_keep", RDATA,           32'h1234_5678);
    repeat (3) tick();

    // Miss: nothing should happen.
    cpu_req(1'b0, 32'h0000_2000, 32'h0);
    repeat (4) tick();
    chk("miss_wait",    32'(WAIT_SIGNAL), 32'(0));
    MEM_REQ = 1'b0;
    tick();

    // Timeout: device never answers.
    ack_lat = 0;
    cpu_req(1'b0, 32'h0000_1020, 32'h0);
    tick();
    MEM_REQ = 1'b0;
    repeat (7) tick();
    chk("to_req_held",  32'(DEV_REQ),     32'(1));
    tick();
    chk("to_req_drop",  32'(DEV_REQ),     32'(0));
    chk("to_rdata",     RDATA,            ERR_VALUE);
    chk("to_err_set",   32'(TIMEOUT_ERR), 32'(1));
    repeat (4) tick();
    chk("to_err_sticky", 32'(TIMEOUT_ERR), 32'(1));
    ERR_CLEAR = 1'b1;
    tick();
    ERR_CLEAR = 1'b0;
    chk("to_err_clear", 32'(TIMEOUT_ERR), 32'(0));

    // Back-to-back with MEM_REQ held; second ack lands on the timeout cycle.
    ack_lat = 2; dev_data = 32'h1111_0000;
    cpu_req(1'b0, 32'h0000_1008, 32'h0);
    tick(); tick(); tick();
    chk("b2b_rdata1",   RDATA,            32'h1111_0000);
    ack_lat = TMO; dev_data = 32'h2222_3333;
    tick();
    chk("b2b_release_done", 32'(WAIT_SIGNAL), 32'(0));
    tick();
    chk("b2b_cooldown", 32'(WAIT_SIGNAL), 32'(0));
    tick();
    chk("b2b_second",   32'(DEV_REQ),     32'(1));
    MEM_REQ = 1'b0;
    repeat (7) tick();
    chk("b2b_req_held", 32'(DEV_REQ),     32'(1));
    tick();
    chk("b2b_hs",       32'(HANDSHAKE),   32'(1));
    chk("b2b_rdata2",   RDATA,            32'h2222_3333);
    chk("b2b_no_err",   32'(TIMEOUT_ERR), 32'(0));
    repeat (3) tick();

    // Asynchronous reset in the middle of ISSUE.
    ack_lat = 0;
    cpu_req(1'b0, 32'h0000_1030, 32'h0);
    tick();
    MEM_REQ = 1'b0;
    repeat (3) tick();
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_req_drop",  32'(DEV_REQ),     32'(0));
    chk("rst_wait_drop", 32'(WAIT_SIGNAL), 32'(0));
    @(negedge MASTER_CLK);
    RESET_N = 1'b1;
    tick();
    ack_lat = 2; dev_data = 32'h0BAD_F00D;
    cpu_req(1'b0, 32'h0000_1034, 32'h0);
    tick();
    MEM_REQ = 1'b0;
    tick(); tick();
    chk("post_rst_hs",    32'(HANDSHAKE), 32'(1));
    chk("post_rst_rdata", RDATA,          32'h0BAD_F00D);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
